// File: rtl/fft5_pkg.sv
// fft5_pkg
//   Shared definitions for the fft_5 datapath helpers: the multiplier-arbiter
//   FSM state encoding, default operand/result widths and a constant-time
//   clog2 helper usable in parameter expressions.
package fft5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DW_DEF = 12;
  localparam int RW_DEF = 24;

  // Smallest r with 2**r >= value (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((1 << i) < value) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// rr_arbiter_5
//   Combinational round-robin picker: returns the first asserted request at
//   or after the pointer, wrapping cyclically, plus a found flag.
// Ports
//   i_req_valid  in  N_REQ  request lines
//   i_rr_ptr     in  IDW    highest-priority index this cycle
//   o_grant      out IDW    chosen index (0 when nothing found)
//   o_found      out 1      at least one request asserted
module rr_arbiter_5 #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDW-1:0]   i_rr_ptr,
  output logic [IDW-1:0]   o_grant,
  output logic             o_found
);

  // Scan offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    int w_sum;
    int w_idx;
    o_grant = '0;
    o_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum   = int'(i_rr_ptr) + k;
      w_idx   = (w_sum >= N_REQ) ? w_sum - N_REQ : w_sum;
      o_grant = i_req_valid[w_idx[IDW-1:0]] ? w_idx[IDW-1:0] : o_grant;
      o_found = i_req_valid[w_idx[IDW-1:0]] ? 1'b1 : o_found;
    end
  end

endmodule

// File: rtl/cmult_arbiter_5.sv
// cmult_arbiter_5
//   Shares a single complex multiplier among N_REQ fft_5 requesters. One
//   multiply is in flight at a time; requesters are served round-robin, the
//   operands are latched at grant, the multiplier is held enabled until all
//   four result_rdy lines are high, and the result is returned tagged with
//   the requester ID. A watchdog turns a hung multiplier into an error
//   response with zeroed data.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request / one-cycle grant strobe
//   req_ops                 {a,b,c,d} per requester, requester i at i*4*DW
//   rsp_valid/rsp_ready     result handshake
//   rsp_id/real/img/err     tagged result, err = watchdog timeout
//   cm_a..cm_d, cm_en       multiplier operands and enable
//   cm_rdy, cm_real, cm_img multiplier ready lines and results
//   busy                    FSM is not IDLE
module cmult_arbiter_5 import fft5_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int IDW     = clog2(N_REQ),
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*4*DW-1:0] req_ops,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [RW-1:0]         rsp_real,
  output logic [RW-1:0]         rsp_img,
  output logic                  rsp_err,
  output logic [DW-1:0]         cm_a,
  output logic [DW-1:0]         cm_b,
  output logic [DW-1:0]         cm_c,
  output logic [DW-1:0]         cm_d,
  output logic                  cm_en,
  input  logic [3:0]            cm_rdy,
  input  logic [RW-1:0]         cm_real,
  input  logic [RW-1:0]         cm_img,
  output logic                  busy
);

  localparam int TW = clog2(TIMEOUT);

  state_t           r_state,     w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [TW-1:0]    r_timer,     w_timer_nxt;
  logic [N_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [IDW-1:0]   r_rsp_id,    w_rsp_id_nxt;
  logic [RW-1:0]    r_rsp_real,  w_rsp_real_nxt;
  logic [RW-1:0]    r_rsp_img,   w_rsp_img_nxt;
  logic             r_rsp_err,   w_rsp_err_nxt;
  logic [DW-1:0]    r_cm_a,      w_cm_a_nxt;
  logic [DW-1:0]    r_cm_b,      w_cm_b_nxt;
  logic [DW-1:0]    r_cm_c,      w_cm_c_nxt;
  logic [DW-1:0]    r_cm_d,      w_cm_d_nxt;
  logic             r_cm_en,     w_cm_en_nxt;
  logic             r_busy;

  logic [IDW-1:0]   w_grant;
  logic             w_found;
  logic [4*DW-1:0]  w_ops_sel;

  rr_arbiter_5 #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_found     (w_found)
  );

  assign w_ops_sel = req_ops[int'(w_grant)*4*DW +: 4*DW];

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_timer_nxt     = r_timer;
    w_req_ready_nxt = '0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_real_nxt  = r_rsp_real;
    w_rsp_img_nxt   = r_rsp_img;
    w_rsp_err_nxt   = r_rsp_err;
    w_cm_a_nxt      = r_cm_a;
    w_cm_b_nxt      = r_cm_b;
    w_cm_c_nxt      = r_cm_c;
    w_cm_d_nxt      = r_cm_d;
    w_cm_en_nxt     = r_cm_en;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          // Operands and enable rise together, so the multiplier never
          // sees cm_en with stale operands.
          w_req_ready_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant;
          w_cm_a_nxt      = w_ops_sel[4*DW-1 -: DW];
          w_cm_b_nxt      = w_ops_sel[3*DW-1 -: DW];
          w_cm_c_nxt      = w_ops_sel[2*DW-1 -: DW];
          w_cm_d_nxt      = w_ops_sel[DW-1:0];
          w_rsp_id_nxt    = w_grant;
          w_rr_ptr_nxt    = (w_grant == IDW'(N_REQ-1)) ? '0 : w_grant + IDW'(1);
          w_cm_en_nxt     = 1'b1;
          w_state_nxt     = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        w_timer_nxt = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (&cm_rdy) begin
          w_rsp_real_nxt  = cm_real;
          w_rsp_img_nxt   = cm_img;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_cm_en_nxt     = 1'b0;
          w_state_nxt     = RESP;
        end else if (r_timer == TW'(TIMEOUT-1)) begin
          w_rsp_real_nxt  = '0;
          w_rsp_img_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_cm_en_nxt     = 1'b0;
          w_state_nxt     = RESP;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      RESP: begin
        // Returning to IDLE costs a cycle, so no grant overlaps the handshake.
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cm_en_nxt = 1'b0;
      end
    endcase
  end

  // State, operand, result and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_timer     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_real  <= '0;
      r_rsp_img   <= '0;
      r_rsp_err   <= 1'b0;
      r_cm_a      <= '0;
      r_cm_b      <= '0;
      r_cm_c      <= '0;
      r_cm_d      <= '0;
      r_cm_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_timer     <= w_timer_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_real  <= w_rsp_real_nxt;
      r_rsp_img   <= w_rsp_img_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cm_a      <= w_cm_a_nxt;
      r_cm_b      <= w_cm_b_nxt;
      r_cm_c      <= w_cm_c_nxt;
      r_cm_d      <= w_cm_d_nxt;
      r_cm_en     <= w_cm_en_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_real  = r_rsp_real;
  assign rsp_img   = r_rsp_img;
  assign rsp_err   = r_rsp_err;
  assign cm_a      = r_cm_a;
  assign cm_b      = r_cm_b;
  assign cm_c      = r_cm_c;
  assign cm_d      = r_cm_d;
  assign cm_en     = r_cm_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cmult_arbiter_5.sv
// tb_cmult_arbiter_5
//   Directed and random bench for cmult_arbiter_5 with a behavioural
//   complex multiplier of programmable latency that can also be forced to
//   hang with partial ready.
module tb_cmult_arbiter_5;

  localparam int N_REQ = 4;
  localparam int DW    = 12;
  localparam int RW    = 24;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_REQ-1:0]      req_valid = '0;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*4*DW-1:0] req_ops = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [RW-1:0]         rsp_real;
  logic [RW-1:0]         rsp_img;
  logic                  rsp_err;
  logic [DW-1:0]         cm_a, cm_b, cm_c, cm_d;
  logic                  cm_en;
  logic [3:0]            cm_rdy = 4'b0000;
  logic [RW-1:0]         cm_real = '0;
  logic [RW-1:0]         cm_img = '0;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  cmult_arbiter_5 #(
    .N_REQ (N_REQ), .DW (DW), .RW (RW), .IDW (IDW), .TIMEOUT (40)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready), .req_ops (req_ops),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
    .rsp_real (rsp_real), .rsp_img (rsp_img), .rsp_err (rsp_err),
    .cm_a (cm_a), .cm_b (cm_b), .cm_c (cm_c), .cm_d (cm_d), .cm_en (cm_en),
    .cm_rdy (cm_rdy), .cm_real (cm_real), .cm_img (cm_img), .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference complex multiply: ((ac-bd)>>>7, (ad+bc)>>>7), truncated to RW.
  function automatic logic [47:0] mref(input logic [47:0] ops);
    logic signed [DW-1:0] a, b, c, d;
    logic signed [25:0]   re, im;
    {a, b, c, d} = ops;
    re = (a * c) - (b * d);
    im = (a * d) + (b * c);
    re = re >>> 7;
    im = im >>> 7;
    return {re[23:0], im[23:0]};
  endfunction

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    return {a[11:0], b[11:0], c[11:0], d[11:0]};
  endfunction

  // Behavioural multiplier: partial ready first, all ready after lat cycles.
  int lat = 3;
  bit hung = 1'b0;
  int mcnt = 0;
  always @(negedge clk) begin
    if (!cm_en) begin
      mcnt   = 0;
      cm_rdy = 4'b0000;
    end else begin
      mcnt++;
      if (hung) begin
        cm_rdy = 4'b0111;
      end else if (mcnt >= lat) begin
        cm_rdy = 4'b1111;
        {cm_real, cm_img} = mref({cm_a, cm_b, cm_c, cm_d});
      end else begin
        cm_rdy  = 4'b0011;
        cm_real = 24'h5A5A5A;
        cm_img  = 24'hA5A5A5;
      end
    end
  end

  task automatic wait_grant(output int g, output int n);
    g = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 200);
    if (req_ready == '0) begin
      check_eq("grant_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int g, n, bad;
    logic [47:0] exp_res;
    int exp_id, acc, got, cyc;
    bit pend;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_id}, 32'd0);
    check_eq("rst_rsp_data", rsp_real | rsp_img, 32'd0);
    check_eq("rst_cm", {cm_a, cm_b, cm_en, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single op on requester 0
    req_ops[0*48 +: 48] = pk(300, 200, 400, 100);
    req_valid = 4'b0001;
    wait_grant(g, n);
    check_eq("t1_grant", g, 32'd0);
    check_eq("t1_req_ready", {28'd0, req_ready}, 32'd1);
    check_eq("t1_cm_a", {20'd0, cm_a}, 32'd300);
    check_eq("t1_cm_d", {20'd0, cm_d}, 32'd100);
    check_eq("t1_en_busy", {30'd0, cm_en, busy}, 32'd3);
    req_valid = 4'b0000;
    @(negedge clk);
    check_eq("t1_pulse_once", {28'd0, req_ready}, 32'd0);
    wait_rsp(n);
    check_eq("t1_latency", n + 1, 32'd3);
    check_eq("t1_id", {30'd0, rsp_id}, 32'd0);
    check_eq("t1_real", {8'd0, rsp_real}, 32'd781);
    check_eq("t1_img", {8'd0, rsp_img}, 32'd859);
    check_eq("t1_err_en", {30'd0, rsp_err, cm_en}, 32'd0);
    rsp_take();

    // 2: all four requesters from reset, round-robin with wrap
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, n);
      check_eq($sformatf("t2_grant%0d", k), g, k % 4);
      if (k == 4) req_valid = 4'b0000;
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t2_idle", {31'd0, busy}, 32'd0);
    rsp_ready = 1'b0;

    // 3: response stall, no grants while held in RESP
    req_ops[1*48 +: 48] = pk(-100, 50, 20, -30);
    req_valid = 4'b0010;
    wait_grant(g, n);
    check_eq("t3_grant", g, 32'd1);
    req_valid = 4'b0000;
    wait_rsp(n);
    check_eq("t3_real", {8'd0, rsp_real}, 32'h00FFFFFC);
    check_eq("t3_img", {8'd0, rsp_img}, 32'd31);
    req_ops[2*48 +: 48] = pk(10, 0, 128, 0);
    req_valid = 4'b0100;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_real !== 24'hFFFFFC || rsp_img !== 24'd31 ||
          rsp_id !== 2'd1 || req_ready !== 4'b0000) bad++;
    end
    check_eq("t3_stall_stable", bad, 32'd0);
    rsp_take();
    wait_grant(g, n);
    check_eq("t3_next_grant", g, 32'd2);
    req_valid = 4'b0000;
    wait_rsp(n);
    check_eq("t3_next_real", {8'd0, rsp_real}, 32'd10);
    check_eq("t3_next_img", {8'd0, rsp_img}, 32'd0);
    check_eq("t3_next_id", {30'd0, rsp_id}, 32'd2);
    rsp_take();

    // 4: hung multiplier, partial ready only
    hung = 1'b1;
    req_ops[3*48 +: 48] = pk(1, 1, 1, 1);
    req_valid = 4'b1000;
    wait_grant(g, n);
    check_eq("t4_grant", g, 32'd3);
    req_valid = 4'b0000;
    wait_rsp(n);
    check_eq("t4_timeout_lat", n, 32'd41);
    check_eq("t4_err", {31'd0, rsp_err}, 32'd1);
    check_eq("t4_data_zero", {8'd0, rsp_real | rsp_img}, 32'd0);
    check_eq("t4_id", {30'd0, rsp_id}, 32'd3);
    check_eq("t4_en_low", {31'd0, cm_en}, 32'd0);
    hung = 1'b0;
    rsp_take();
    req_ops[0*48 +: 48] = pk(-300, 200, 400, -100);
    req_valid = 4'b0001;
    wait_grant(g, n);
    check_eq("t4_recover_grant", g, 32'd0);
    req_valid = 4'b0000;
    wait_rsp(n);
    check_eq("t4_recover", {7'd0, rsp_err, rsp_real}, 32'h00FFFCF2);
    check_eq("t4_recover_img", {8'd0, rsp_img}, 32'd859);
    rsp_take();

    // 5: reset during WAIT
    hung = 1'b1;
    req_valid = 4'b0010;
    wait_grant(g, n);
    check_eq("t5_grant", g, 32'd1);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("t5_pre_busy", {30'd0, cm_en, busy}, 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("t5_async_clear", {29'd0, cm_en, busy, rsp_valid}, 32'd0);
    hung = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    wait_grant(g, n);
    check_eq("t5_first_grant", g, 32'd0);
    req_valid = 4'b0000;
    wait_rsp(n);
    rsp_take();

    // 6: random traffic scoreboard
    pend = 1'b0;
    acc = 0;
    got = 0;
    exp_id = 0;
    exp_res = '0;
    for (cyc = 0; cyc < 40000 && !(acc >= 1000 && !pend); cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = -1;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
        check_eq("t6_overlap", {31'd0, pend}, 32'd0);
        exp_res = mref(req_ops[g*48 +: 48]);
        exp_id = g;
        pend = 1'b1;
        acc++;
        req_valid[g] = 1'b0;
        lat = $urandom_range(1, 5);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        check_eq("t6_pending", {31'd0, pend}, 32'd1);
        check_eq("t6_id", {30'd0, rsp_id}, exp_id);
        check_eq("t6_real", {8'd0, rsp_real}, {8'd0, exp_res[47:24]});
        check_eq("t6_img_err", {7'd0, rsp_err, rsp_img}, {8'd0, exp_res[23:0]});
        pend = 1'b0;
        got++;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (acc >= 1000) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_ops[i*48 +: 48] = {$urandom, $urandom};
          req_valid[i] = 1'b1;
        end
      end
    end
    check_eq("t6_finished", {31'd0, (cyc < 40000)}, 32'd1);
    check_eq("t6_all_returned", got, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
